// File: rtl/gaussian_stream_filter.sv
// Streaming 3x3 Gaussian blur with two line buffers and a two-stage valid/ready pipeline.
// Define GAUSS_ROUND_EN for round-half-up output; the default build truncates.
module gaussian_stream_filter #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int SW = DATA_W + 4;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [DATA_W-1:0] lb0 [IMG_W];
   logic [DATA_W-1:0] lb1 [IMG_W];
   logic [DATA_W-1:0] win [3][3];
   logic              s1_valid;
   logic              s1_last;
   logic              adv;
   logic              accept;
   logic              complete;
   logic              frame_end;
   logic [SW-1:0]     sum;
   logic [DATA_W-1:0] pix;

   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
   assign accept    = in_valid && adv;
   assign complete  = (row >= RW'(2)) && (col >= CW'(2));
   assign frame_end = (row == ROW_LAST) && (col == COL_LAST);

   // Row 0 of the window is the oldest line (r-2); column 2 is the newest pixel.
   assign sum = SW'(win[0][0]) + SW'(win[0][2]) + SW'(win[2][0]) + SW'(win[2][2])
              + (SW'(win[0][1]) << 1) + (SW'(win[1][0]) << 1)
              + (SW'(win[1][2]) << 1) + (SW'(win[2][1]) << 1)
              + (SW'(win[1][1]) << 2);

`ifdef GAUSS_ROUND_EN
   assign pix = DATA_W'((sum + SW'(8)) >> 4);
`else
   assign pix = DATA_W'(sum >> 4);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         col       <= '0;
         row       <= '0;
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         done      <= 1'b0;
      end else begin
         done <= out_valid && out_ready && out_last;
         if (adv) begin
            s1_valid  <= accept && complete;
            s1_last   <= frame_end;
            out_valid <= s1_valid;
            out_last  <= s1_valid && s1_last;
            out_data  <= pix;
         end
         if (accept) begin
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
      end
   end

   // Line buffers and window carry no reset; completeness gating hides stale contents.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[col] <= lb0[col];
         lb0[col] <= in_data;
         for (int i = 0; i < 3; i++) begin
            win[i][0] <= win[i][1];
            win[i][1] <= win[i][2];
         end
         win[0][2] <= lb1[col];
         win[1][2] <= lb0[col];
         win[2][2] <= in_data;
      end
   end

endmodule
